// File: rtl/draw_scheduler.sv
// Sequences shape drawers each frame: clear screen, one player frame, then every obstacle.
// Legal configurations need N_ANIM >= 2 and N_SHAPES >= N_ANIM + 2.
module draw_scheduler #(
  parameter  int N_SHAPES = 18,
  parameter  int N_ANIM   = 7,
  parameter  int COORD_W  = 11,
  parameter  int COLOUR_W = 3,
  localparam int ID_W     = $clog2(N_SHAPES)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start_switch,
  input  logic                           jump_n,
  input  logic                           frame_tick,
  input  logic [N_SHAPES-1:0]            draw_done,
  input  logic [N_SHAPES*COORD_W-1:0]    x_bus,
  input  logic [N_SHAPES*COORD_W-1:0]    y_bus,
  input  logic [N_SHAPES*COLOUR_W-1:0]   colour_bus,
  output logic                           enable,
  output logic [N_SHAPES-1:0]            draw_start,
  output logic [N_SHAPES-1:0]            shape_reset,
  output logic [ID_W-1:0]                cur_id,
  output logic [COORD_W-1:0]             out_x,
  output logic [COORD_W-1:0]             out_y,
  output logic [COLOUR_W-1:0]            out_colour,
  output logic [7:0]                     overrun_count
);

  localparam logic [ID_W-1:0] CLR_ID     = ID_W'(N_SHAPES - 1);
  localparam logic [ID_W-1:0] FIRST_OBST = ID_W'(N_ANIM);
  localparam logic [ID_W-1:0] LAST_OBST  = ID_W'(N_SHAPES - 2);
  localparam logic [ID_W-1:0] IDLE_FRAME = ID_W'(N_ANIM - 1);
  localparam logic [ID_W-1:0] LAST_ANIM  = ID_W'(N_ANIM - 2);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_PLAYER, S_OBST, S_WAIT, S_SHUT} state_t;
  // GAP is the one idle cycle inserted when a draw is aborted by shutdown
  typedef enum logic [1:0] {PH_ISSUE, PH_RELEASE, PH_GAP} phase_t;

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic [ID_W-1:0] cur_id_q, cur_id_d;
  logic [ID_W-1:0] anim_idx_q, anim_idx_d;
  logic            anim_active_q, anim_active_d;
  logic            jump_pend_q, jump_pend_d;
  logic            tick_pend_q, tick_pend_d;
  logic [7:0]      overrun_q, overrun_d;

  logic drawing, running, done_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      phase_q       <= PH_ISSUE;
      cur_id_q      <= CLR_ID;
      anim_idx_q    <= '0;
      anim_active_q <= 1'b0;
      jump_pend_q   <= 1'b0;
      tick_pend_q   <= 1'b0;
      overrun_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      cur_id_q      <= cur_id_d;
      anim_idx_q    <= anim_idx_d;
      anim_active_q <= anim_active_d;
      jump_pend_q   <= jump_pend_d;
      tick_pend_q   <= tick_pend_d;
      overrun_q     <= overrun_d;
    end
  end

  assign drawing = (state_q == S_CLEAR) || (state_q == S_PLAYER) ||
                   (state_q == S_OBST)  || (state_q == S_SHUT);
  assign running = (state_q == S_CLEAR) || (state_q == S_PLAYER) ||
                   (state_q == S_OBST)  || (state_q == S_WAIT);

  always_comb begin
    done_hit   = 1'b0;
    draw_start = '0;
    out_x      = '0;
    out_y      = '0;
    out_colour = '0;
    for (int k = 0; k < N_SHAPES; k++) begin
      if (cur_id_q == ID_W'(k)) begin
        done_hit      = draw_done[k];
        draw_start[k] = drawing && (phase_q == PH_ISSUE);
        out_x         = x_bus[k*COORD_W +: COORD_W];
        out_y         = y_bus[k*COORD_W +: COORD_W];
        out_colour    = colour_bus[k*COLOUR_W +: COLOUR_W];
      end
    end
  end

  assign enable        = (state_q != S_IDLE);
  assign shape_reset   = {N_SHAPES{state_q == S_IDLE}};
  assign cur_id        = cur_id_q;
  assign overrun_count = overrun_q;

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    cur_id_d      = cur_id_q;
    anim_idx_d    = anim_idx_q;
    anim_active_d = anim_active_q;
    jump_pend_d   = jump_pend_q;
    tick_pend_d   = tick_pend_q;
    overrun_d     = overrun_q;

    if (state_q != S_IDLE && !jump_n) jump_pend_d = 1'b1;
    // A tick arriving while a frame is still being drawn is late: remember it and count it
    if (frame_tick && state_q != S_IDLE && state_q != S_WAIT) begin
      tick_pend_d = 1'b1;
      if (overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
    end

    if (state_q == S_IDLE) begin
      cur_id_d = CLR_ID;
      if (start_switch) begin
        state_d = S_CLEAR;
        phase_d = PH_ISSUE;
      end
    end else if (running && !start_switch) begin
      state_d  = S_SHUT;
      phase_d  = PH_GAP;
      cur_id_d = CLR_ID;
    end else if (state_q == S_WAIT) begin
      if (frame_tick || tick_pend_q) begin
        state_d     = S_CLEAR;
        phase_d     = PH_ISSUE;
        cur_id_d    = CLR_ID;
        tick_pend_d = 1'b0;
      end
    end else begin
      unique case (phase_q)
        PH_ISSUE: if (done_hit) phase_d = PH_RELEASE;
        PH_GAP:   phase_d = PH_ISSUE;
        default: begin
          phase_d = PH_ISSUE;
          case (state_q)
            S_CLEAR: begin
              state_d = S_PLAYER;
              if (anim_active_q) begin
                cur_id_d = anim_idx_q;
              end else if (jump_pend_q) begin
                anim_active_d = 1'b1;
                jump_pend_d   = 1'b0;
                anim_idx_d    = '0;
                cur_id_d      = '0;
              end else begin
                cur_id_d = IDLE_FRAME;
              end
            end
            S_PLAYER: begin
              state_d  = S_OBST;
              cur_id_d = FIRST_OBST;
              if (anim_active_q) begin
                if (anim_idx_q == LAST_ANIM) begin
                  anim_active_d = 1'b0;
                  anim_idx_d    = '0;
                end else begin
                  anim_idx_d = anim_idx_q + ID_W'(1);
                end
              end
            end
            S_OBST: begin
              if (cur_id_q == LAST_OBST) begin
                state_d  = S_WAIT;
                cur_id_d = CLR_ID;
              end else begin
                cur_id_d = cur_id_q + ID_W'(1);
              end
            end
            default: begin
              state_d       = S_IDLE;
              cur_id_d      = CLR_ID;
              anim_active_d = 1'b0;
              anim_idx_d    = '0;
              jump_pend_d   = 1'b0;
              tick_pend_d   = 1'b0;
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler: expected draw ids are queued by the stimulus
// and checked by a monitor every time a new draw_start request appears.
`timescale 1ns/1ps
module tb_draw_scheduler;
  localparam int NS  = 18;
  localparam int NA  = 7;
  localparam int CW  = 11;
  localparam int KW  = 3;
  localparam int IDW = 5;
  localparam int CLR = NS - 1;

  logic              clock = 1'b0;
  logic              reset, start_switch, jump_n, frame_tick;
  logic [NS-1:0]     draw_done, draw_start, shape_reset;
  logic [NS*CW-1:0]  x_bus, y_bus;
  logic [NS*KW-1:0]  colour_bus;
  logic              enable;
  logic [IDW-1:0]    cur_id;
  logic [CW-1:0]     out_x, out_y;
  logic [KW-1:0]     out_colour;
  logic [7:0]        overrun_count;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int dcnt = 0;
  logic [NS-1:0] mon_prev;
  int mon_e;

  draw_scheduler #(.N_SHAPES(NS), .N_ANIM(NA), .COORD_W(CW), .COLOUR_W(KW)) dut (
    .clock(clock), .reset(reset), .start_switch(start_switch), .jump_n(jump_n),
    .frame_tick(frame_tick), .draw_done(draw_done), .x_bus(x_bus), .y_bus(y_bus),
    .colour_bus(colour_bus), .enable(enable), .draw_start(draw_start),
    .shape_reset(shape_reset), .cur_id(cur_id), .out_x(out_x), .out_y(out_y),
    .out_colour(out_colour), .overrun_count(overrun_count)
  );

  always #5 clock = ~clock;

  // Drawer model: completes two cycles after its start request appears
  always @(posedge clock) begin
    if (draw_start != '0) dcnt <= dcnt + 1;
    else                  dcnt <= 0;
  end
  always_comb draw_done = (dcnt == 2) ? draw_start : '0;

  function automatic logic [NS-1:0] oh(input int id);
    logic [NS-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_issue(input int id);
    int n;
    n = 0;
    while (!draw_start[id] && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!draw_start[id]) begin
      checks++;
      errors++;
      $display("FAIL wait_issue: id %0d never requested, got draw_start=%0h", id, draw_start);
    end
  endtask

  task automatic push_frame(input int player, input int last_obst);
    exp_q.push_back(CLR);
    exp_q.push_back(player);
    for (int k = NA; k <= last_obst; k++) exp_q.push_back(k);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
  endtask

  task automatic jump();
    jump_n = 1'b0;
    cyc(1);
    jump_n = 1'b1;
  endtask

  task automatic end_frame();
    wait_issue(NS - 2);
    cyc(4);
  endtask

  // Monitor: every new draw request must match the next expected id
  initial begin
    mon_prev = '0;
    forever begin
      @(negedge clock);
      check("onehot", {31'd0, $countones(draw_start) <= 1}, 32'd1);
      if (draw_start != '0 && draw_start != mon_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL issue: unexpected draw_start=%0h", draw_start);
        end else begin
          mon_e = exp_q.pop_front();
          check("issue_id", 32'(draw_start), 32'(oh(mon_e)));
          check("issue_cur_id", 32'(cur_id), 32'(mon_e));
          check("issue_out_x", 32'(out_x), 32'(mon_e * 3 + 1));
          check("issue_out_colour", 32'(out_colour), 32'(mon_e % 8));
        end
      end
      mon_prev = draw_start;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NS; k++) begin
      x_bus[k*CW +: CW]      = CW'(k * 3 + 1);
      y_bus[k*CW +: CW]      = CW'(k + 100);
      colour_bus[k*KW +: KW] = KW'(k % 8);
    end
    reset = 1'b1; start_switch = 1'b0; jump_n = 1'b1; frame_tick = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check("rst_enable", 32'(enable), 0);
    check("rst_shape_reset", 32'(shape_reset), 32'(18'h3FFFF));
    check("rst_draw_start", 32'(draw_start), 0);
    check("rst_cur_id", 32'(cur_id), CLR);
    check("rst_overrun", 32'(overrun_count), 0);

    // First frame after start: idle player frame
    push_frame(NA - 1, NS - 2);
    start_switch = 1'b1;
    cyc(1);
    check("start_enable", 32'(enable), 1);
    check("start_shape_reset", 32'(shape_reset), 0);
    end_frame();
    cyc(3);
    check("wait_no_draw", 32'(draw_start), 0);

    // Single jump: six animation frames then idle frame
    jump();
    for (int f = 0; f < 7; f++) begin
      push_frame(f, NS - 2);
      tick();
      end_frame();
    end

    // Jumps during frames 2 and 4 queue exactly one new animation
    jump();
    for (int f = 1; f <= 7; f++) begin
      push_frame((f == 7) ? 0 : f - 1, NS - 2);
      tick();
      if (f == 2 || f == 4) jump();
      end_frame();
    end

    // Two late ticks in frame 8; frame 9 then starts without a new tick
    push_frame(1, NS - 2);
    push_frame(2, 9);
    tick();
    wait_issue(8);
    tick();
    wait_issue(10);
    tick();
    end_frame();
    check("wait_exit_gap", 32'(draw_start), 0);
    cyc(1);
    check("auto_clear", 32'(draw_start), 32'(oh(CLR)));
    check("overrun2", 32'(overrun_count), 2);

    // Shutdown mid-draw of obstacle 9
    wait_issue(9);
    exp_q.push_back(CLR);
    start_switch = 1'b0;
    cyc(1);
    check("shut_drop", 32'(draw_start), 0);
    wait_issue(CLR);
    push_frame(NA - 1, 12);
    start_switch = 1'b1;
    cyc(4);
    check("shut_enable", 32'(enable), 0);
    check("shut_shape_reset", 32'(shape_reset), 32'(18'h3FFFF));
    check("shut_cur_id", 32'(cur_id), CLR);
    check("shut_overrun_kept", 32'(overrun_count), 2);
    cyc(1);
    check("restart_enable", 32'(enable), 1);

    // Reset in the middle of the request for obstacle 12
    wait_issue(12);
    reset = 1'b1;
    start_switch = 1'b0;
    cyc(1);
    check("mid_rst_draw_start", 32'(draw_start), 0);
    check("mid_rst_enable", 32'(enable), 0);
    check("mid_rst_shape_reset", 32'(shape_reset), 32'(18'h3FFFF));
    check("mid_rst_cur_id", 32'(cur_id), CLR);
    check("mid_rst_overrun", 32'(overrun_count), 0);
    reset = 1'b0;
    cyc(3);
    check("post_rst_idle", 32'(draw_start), 0);
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
